csr_unit: RTL and testbench

//   Machine-mode RISC-V Zicsr CSR unit; next generation of the masked CSR register file.

---
 rtl/csr_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit: machine-mode Zicsr CSR file with trap state, counters and illegal-access detection.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise those CSRs read 0 and ignore writes.
module csr_unit #(
    parameter logic [31:0] HART_ID       = 32'd0,
    parameter int          COUNTER_WIDTH = 64,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [11:0] addr_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] wr_data_in,
    output logic [31:0] rd_data_out,
    output logic        illegal_out,
    input  logic        instret_in,
    input  logic        trap_in,
    input  logic [31:0] trap_pc_in,
    input  logic [31:0] trap_cause_in,
    input  logic [31:0] trap_val_in,
    input  logic        mret_in,
    output logic [31:0] epc_out,
    output logic [31:0] tvec_out,
    output logic        mie_out
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        mie_q, mpie_q;
    logic [29:0] mtvec_q, mepc_q;
    logic [31:0] mscratch_q, mcause_q, mtval_q;
    logic [63:0] mcycle_w, minstret_w;
    logic        mapped, wr_occurs, csr_we;
    logic [31:0] old_val, wval;

    // Read mux: also the "old" operand for set/clear.
    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (addr_in)
            A_MSTATUS:              old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            A_MTVEC:                old_val = {mtvec_q, 2'b00};
            A_MSCRATCH:             old_val = mscratch_q;
            A_MEPC:                 old_val = {mepc_q, 2'b00};
            A_MCAUSE:               old_val = mcause_q;
            A_MTVAL:                old_val = mtval_q;
            A_MCYCLE, A_CYCLE:      old_val = mcycle_w[31:0];
            A_MCYCLEH, A_CYCLEH:    old_val = mcycle_w[63:32];
            A_MINSTRET, A_INSTRET:  old_val = minstret_w[31:0];
            A_MINSTRETH, A_INSTRETH: old_val = minstret_w[63:32];
            A_MHARTID:              old_val = HART_ID;
            default:                mapped  = 1'b0;
        endcase
    end

    always_comb begin
        wval      = wr_data_in;
        wr_occurs = 1'b0;
        case (op_in)
            2'b01: wr_occurs = 1'b1;
            2'b10: begin
                wval      = old_val | wr_data_in;
                wr_occurs = |wr_data_in;
            end
            2'b11: begin
                wval      = old_val & ~wr_data_in;
                wr_occurs = |wr_data_in;
            end
            default: ;
        endcase
    end

    assign illegal_out = (op_in != 2'b00) && (!mapped || (addr_in[11:10] == 2'b11 && wr_occurs));
    // Trap and mret pre-empt the CSR write completely.
    assign csr_we      = wr_occurs && !illegal_out && !trap_in && !mret_in;
    assign rd_data_out = old_val;
    assign epc_out     = {mepc_q, 2'b00};
    assign tvec_out    = {mtvec_q, 2'b00};
    assign mie_out     = mie_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET[31:2];
            mepc_q     <= '0;
            mscratch_q <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_in) begin
            mepc_q   <= trap_pc_in[31:2];
            mcause_q <= trap_cause_in;
            mtval_q  <= trap_val_in;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_in) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_we) begin
            case (addr_in)
                A_MSTATUS: begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                A_MTVEC:    mtvec_q    <= wval[31:2];
                A_MSCRATCH: mscratch_q <= wval;
                A_MEPC:     mepc_q     <= wval[31:2];
                A_MCAUSE:   mcause_q   <= wval;
                A_MTVAL:    mtval_q    <= wval;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    assign mcycle_w   = 64'(mcycle_q);
    assign minstret_w = 64'(minstret_q);

    // A write to either half replaces the increment for that counter this cycle.
    always_comb begin
        mcycle_d   = mcycle_q + COUNTER_WIDTH'(1);
        minstret_d = minstret_q + COUNTER_WIDTH'(instret_in);
        if (csr_we) begin
            case (addr_in)
                A_MCYCLE:    mcycle_d   = COUNTER_WIDTH'({mcycle_w[63:32], wval});
                A_MCYCLEH:   mcycle_d   = COUNTER_WIDTH'({wval, mcycle_w[31:0]});
                A_MINSTRET:  minstret_d = COUNTER_WIDTH'({minstret_w[63:32], wval});
                A_MINSTRETH: minstret_d = COUNTER_WIDTH'({wval, minstret_w[31:0]});
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    assign mcycle_w   = '0;
    assign minstret_w = '0;
    logic unused_instret;
    assign unused_instret = instret_in;
`endif

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^trap_pc_in[1:0];

endmodule

// File: tb/tb_csr_unit.sv
// Randomized self-checking bench for csr_unit against a behavioural CSR model.
module tb_csr_unit;
    localparam logic [31:0] HART      = 32'h0000_0005;
    localparam logic [31:0] MTVEC_RST = 32'h0000_2003;

    logic        clk = 1'b0;
    logic        arst;
    logic [11:0] addr_in;
    logic [1:0]  op_in;
    logic [31:0] wr_data_in, rd_data_out;
    logic        illegal_out, instret_in, trap_in, mret_in;
    logic [31:0] trap_pc_in, trap_cause_in, trap_val_in;
    logic [31:0] epc_out, tvec_out;
    logic        mie_out;

    csr_unit #(.HART_ID(HART), .COUNTER_WIDTH(64), .MTVEC_RESET(MTVEC_RST)) dut (
        .clk(clk), .arst(arst), .addr_in(addr_in), .op_in(op_in), .wr_data_in(wr_data_in),
        .rd_data_out(rd_data_out), .illegal_out(illegal_out), .instret_in(instret_in),
        .trap_in(trap_in), .trap_pc_in(trap_pc_in), .trap_cause_in(trap_cause_in),
        .trap_val_in(trap_val_in), .mret_in(mret_in), .epc_out(epc_out),
        .tvec_out(tvec_out), .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit              m_mie, m_mpie;
    bit [31:0]       m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    longint unsigned m_cyc, m_ins;
    logic [31:0]     last_rd;
    logic            last_ill;

    task automatic m_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = MTVEC_RST & ~32'h3;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic bit m_mapped(input logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
            12'hC02, 12'hC82, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        longint unsigned c, n;
`ifdef CSR_COUNTERS_EN
        c = m_cyc; n = m_ins;
`else
        c = 0; n = 0;
`endif
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return c[31:0];
            12'hB80, 12'hC80: return c[63:32];
            12'hB02, 12'hC02: return n[31:0];
            12'hB82, 12'hC82: return n[63:32];
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then advance model at posedge.
    task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                        input logic ir = 0, input logic tr = 0, input logic [31:0] pc = 0,
                        input logic [31:0] cause = 0, input logic [31:0] val = 0,
                        input logic mr = 0);
        logic [31:0] old, nv;
        bit wr, ill;
        longint unsigned ncyc, nins;
        @(negedge clk);
        addr_in = a; op_in = op; wr_data_in = d; instret_in = ir;
        trap_in = tr; trap_pc_in = pc; trap_cause_in = cause; trap_val_in = val; mret_in = mr;
        #1;
        old = m_read(a);
        wr  = (op == 2'b01) || (op != 2'b00 && d != 0);
        ill = (op != 2'b00) && (!m_mapped(a) || (a[11:10] == 2'b11 && wr));
        check("rd", rd_data_out, old);
        check("illegal", {31'b0, illegal_out}, {31'b0, ill});
        check("epc", epc_out, m_mepc);
        check("tvec", tvec_out, m_mtvec);
        check("mie", {31'b0, mie_out}, {31'b0, m_mie});
        last_rd = rd_data_out;
        last_ill = illegal_out;
        @(posedge clk);
        nv = (op == 2'b01) ? d : (op == 2'b10) ? (old | d) : (old & ~d);
        ncyc = m_cyc + 1;
        nins = m_ins + (ir ? 1 : 0);
        if (tr) begin
            m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = val;
            m_mpie = m_mie; m_mie = 0;
        end else if (mr) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr && !ill) begin
            case (a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: ncyc = {m_cyc[63:32], nv};
                12'hB80: ncyc = {nv, m_cyc[31:0]};
                12'hB02: nins = {m_ins[63:32], nv};
                12'hB82: nins = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = ncyc;
        m_ins = nins;
    endtask

    logic [11:0] atab [20] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                               12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                               12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h301, 12'h344,
                               12'hF11, 12'hB03};

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            d = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            step(atab[$urandom_range(19)], 2'($urandom_range(3)), d, 1'($urandom_range(1)),
                 ($urandom_range(15) == 0), $urandom, $urandom, $urandom,
                 ($urandom_range(15) == 0));
        end
    endtask

    logic [31:0] r0;

    initial begin
        arst = 1; addr_in = 12'h300; op_in = 0; wr_data_in = 0; instret_in = 0;
        trap_in = 0; trap_pc_in = 0; trap_cause_in = 0; trap_val_in = 0; mret_in = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvec", tvec_out, 32'h0000_2000);
        check("rst_mstatus", rd_data_out, 32'h0000_1800);
        #1 arst = 0;

        step(12'h300, 2'b00, 0);  check("rst_mstatus_rd", last_rd, 32'h0000_1800);
        step(12'h305, 2'b00, 0);  check("rst_mtvec_rd", last_rd, 32'h0000_2000);
        step(12'h342, 2'b00, 0);  check("rst_mcause", last_rd, 32'h0);
        step(12'hF14, 2'b00, 0);  check("mhartid", last_rd, HART);

        step(12'h340, 2'b01, 32'hA5A5_0000);
        step(12'h340, 2'b10, 32'h0000_00FF);  check("rs_old", last_rd, 32'hA5A5_0000);
        step(12'h340, 2'b11, 32'hA500_0000);  check("rc_old", last_rd, 32'hA5A5_00FF);
        step(12'h340, 2'b00, 0);              check("scratch_final", last_rd, 32'h00A5_00FF);

        step(12'hC00, 2'b01, 32'h1);  check("ro_write_ill", {31'b0, last_ill}, 32'h1);
        step(12'hC00, 2'b10, 32'h0);  check("ro_read_ok", {31'b0, last_ill}, 32'h0);
        step(12'h7C0, 2'b01, 32'h1);  check("unmapped_ill", {31'b0, last_ill}, 32'h1);
        check("unmapped_rd", last_rd, 32'h0);

        step(12'h300, 2'b01, 32'h0000_0008);
        step(12'h340, 2'b01, 32'h1234_5678, 0, 1, 32'h0000_1003, 32'h0000_000B, 32'h0000_0077);
        step(12'h341, 2'b00, 0);  check("trap_mepc", last_rd, 32'h0000_1000);
        step(12'h342, 2'b00, 0);  check("trap_mcause", last_rd, 32'h0000_000B);
        step(12'h300, 2'b00, 0);  check("trap_mstatus", last_rd, 32'h0000_1880);
        step(12'h340, 2'b00, 0);  check("trap_no_write", last_rd, 32'h00A5_00FF);
        step(12'h300, 2'b01, 32'h0, 0, 0, 0, 0, 0, 1);
        step(12'h300, 2'b00, 0);  check("mret_mstatus", last_rd, 32'h0000_1888);

`ifdef CSR_COUNTERS_EN
        step(12'hB00, 2'b01, 32'hFFFF_FFFF);
        step(12'hB80, 2'b01, 32'h0);
        step(12'hB00, 2'b00, 0);  check("mcycle_lo_full", last_rd, 32'hFFFF_FFFF);
        step(12'hB80, 2'b00, 0);  check("mcycleh_carry", last_rd, 32'h1);
        step(12'hB02, 2'b00, 0);  r0 = last_rd;
        repeat (10) step(12'hB02, 2'b00, 0, 1);
        step(12'hB02, 2'b00, 0);  check("minstret_plus10", last_rd, r0 + 32'd10);
        step(12'hB02, 2'b01, 32'h0000_0100, 1);
        step(12'hB02, 2'b00, 0);  check("minstret_override", last_rd, 32'h0000_0100);
`else
        repeat (100) step(12'hB00, 2'b00, 0, 1);
        step(12'hB00, 2'b01, 32'h5);  check("nc_b00_legal", {31'b0, last_ill}, 32'h0);
        step(12'hB00, 2'b00, 0);      check("nc_b00", last_rd, 32'h0);
        step(12'hC00, 2'b00, 0);      check("nc_c00", last_rd, 32'h0);
        step(12'hB02, 2'b00, 0);      check("nc_b02", last_rd, 32'h0);
`endif

        random_steps(250);

        @(negedge clk);
        arst = 1; addr_in = 12'h340; op_in = 0; trap_in = 0; mret_in = 0;
        r0 = 32'h0;
        #1;
        m_reset();
        check("arst_scratch", rd_data_out, r0);
        check("arst_tvec", tvec_out, 32'h0000_2000);
        @(posedge clk);
        #1 arst = 0;
        step(12'hB00, 2'b00, 0);  check("arst_counter", last_rd, 32'h0);

        random_steps(250);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
